// File: rtl/int_vect_ctrl_pkg.sv
// Shared definitions for the interrupt vector controller: FSM states,
// entry step limits, priority width and a vector-to-one-hot helper.
package int_vect_ctrl_pkg;

    localparam int NUM_SRC_C = 8;
    localparam int PRI_W     = 3;
    localparam int VEC_W     = 3;
    localparam int FLAG_W    = 16;
    localparam int NUM_STEPS = 9;
    localparam int LAST_STEP = NUM_STEPS - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_ENTRY,
        ST_ACK
    } state_t;

    // One-hot 16-bit vector flag for a source index.
    function automatic logic [FLAG_W-1:0] vec_onehot(input logic [VEC_W-1:0] vec);
        return FLAG_W'(1) << vec;
    endfunction

endpackage

// File: rtl/int_prio_arb.sv
// Combinational winner select: highest priority among qualifying sources,
// ties resolved towards the lowest index.
module int_prio_arb
    import int_vect_ctrl_pkg::*;
(
    input  logic [NUM_SRC_C-1:0]            qual,
    input  logic [NUM_SRC_C-1:0][PRI_W-1:0] pri_tbl,
    output logic                            found,
    output logic [VEC_W-1:0]                index
);

    logic [PRI_W-1:0] best;

    // Scan upward; only a strictly higher priority displaces the current pick.
    always_comb begin
        found = 1'b0;
        index = '0;
        best  = '0;
        for (int i = 0; i < NUM_SRC_C; i++) begin
            if (qual[i] && (!found || (pri_tbl[i] > best))) begin
                found = 1'b1;
                index = VEC_W'(i);
                best  = pri_tbl[i];
            end
        end
    end

endmodule

// File: rtl/int_vect_ctrl.sv
// Interrupt vector controller: latches level requests, arbitrates at an
// instruction boundary and sequences a nine-step entry ending in a one-cycle
// acknowledge. Define INT_CTRL_NMI_EN to make source 7 non-maskable.
module int_vect_ctrl
    import int_vect_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SRC-1:0]  irq_in,
    input  logic [PRI_W-1:0]    psw_pri,
    input  logic                inst_boundary,
    input  logic                step_done,
    input  logic                pri_wr,
    input  logic [VEC_W-1:0]    pri_addr,
    input  logic [PRI_W-1:0]    pri_data,
    output logic [FLAG_W-1:0]   iv_flags,
    output logic [3:0]          counter,
    output logic [NUM_SRC-1:0]  irq_ack,
    output logic                busy
);

    state_t                          state, state_nxt;
    logic [NUM_SRC-1:0]              pending;
    logic [NUM_SRC-1:0]              qual;
    logic [NUM_SRC-1:0][PRI_W-1:0]   pri_tbl;
    logic [VEC_W-1:0]                vec;
    logic                            arb_found;
    logic [VEC_W-1:0]                arb_index;
    logic                            win_found;
    logic [VEC_W-1:0]                win_index;
    logic                            load_vec;
    logic                            last_step;

    assign last_step = (counter == 4'(LAST_STEP));

    // Requests stick until acknowledged; the acknowledge clear beats a new set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | irq_in) & ~irq_ack;
        end
    end

    // Priority table is writable at any time and resets to identity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                pri_tbl[i] <= PRI_W'(i);
            end
        end else if (pri_wr) begin
            pri_tbl[pri_addr] <= pri_data;
        end
    end

    // A source qualifies when pending and strictly above the PSW priority.
    always_comb begin
        qual = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            qual[i] = pending[i] && (pri_tbl[i] > psw_pri);
        end
`ifdef INT_CTRL_NMI_EN
        qual[NUM_SRC-1] = pending[NUM_SRC-1];
`endif
    end

    int_prio_arb u_arb (
        .qual    (qual),
        .pri_tbl (pri_tbl),
        .found   (arb_found),
        .index   (arb_index)
    );

    // The non-maskable source, when enabled, overrides the priority winner.
    always_comb begin
        win_found = arb_found;
        win_index = arb_index;
`ifdef INT_CTRL_NMI_EN
        if (qual[NUM_SRC-1]) begin
            win_index = VEC_W'(NUM_SRC - 1);
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; qualification (and so psw_pri) only matters in IDLE/ARB.
    always_comb begin
        state_nxt = state;
        load_vec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((|qual) && inst_boundary) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (win_found) begin
                    state_nxt = ST_ENTRY;
                    load_vec  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (step_done && last_step) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latched vector is captured once per entry and held through ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (load_vec) begin
            vec <= win_index;
        end
    end

    // Step counter: cleared on entry, saturates at the last step, cleared into ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (load_vec) begin
            counter <= '0;
        end else if ((state == ST_ENTRY) && step_done) begin
            if (last_step) begin
                counter <= '0;
            end else begin
                counter <= counter + 4'd1;
            end
        end
    end

    // Outputs decode directly from state so reset clears them immediately.
    always_comb begin
        iv_flags = '0;
        irq_ack  = '0;
        if (state == ST_ENTRY) begin
            iv_flags = vec_onehot(vec);
        end
        if (state == ST_ACK) begin
            irq_ack = NUM_SRC'(1) << vec;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_int_vect_ctrl.sv
// Testbench for int_vect_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the controller.
module tb_int_vect_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic [2:0]  psw_pri;
    logic        inst_boundary;
    logic        step_done;
    logic        pri_wr;
    logic [2:0]  pri_addr;
    logic [2:0]  pri_data;
    logic [15:0] iv_flags;
    logic [3:0]  counter;
    logic [7:0]  irq_ack;
    logic        busy;

    int n_cmp;
    int n_bad;

    // Behavioural model: mode 0 idle, 1 arbitrate, 2 entry, 3 acknowledge.
    logic [7:0] m_pend;
    logic [2:0] m_tbl [8];
    int         m_mode;
    int         m_vec;
    int         m_cnt;

    int_vect_ctrl #(.NUM_SRC(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_in        (irq_in),
        .psw_pri       (psw_pri),
        .inst_boundary (inst_boundary),
        .step_done     (step_done),
        .pri_wr        (pri_wr),
        .pri_addr      (pri_addr),
        .pri_data      (pri_data),
        .iv_flags      (iv_flags),
        .counter       (counter),
        .irq_ack       (irq_ack),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_qualifies(int i);
`ifdef INT_CTRL_NMI_EN
        if (i == 7 && m_pend[7]) return 1'b1;
`endif
        return m_pend[i] && (int'(m_tbl[i]) > int'(psw_pri));
    endfunction

    // Winner: non-maskable source first, else highest priority level, lowest index.
    function automatic int m_winner();
`ifdef INT_CTRL_NMI_EN
        if (m_pend[7]) return 7;
`endif
        for (int p = 7; p >= 1; p--) begin
            for (int i = 0; i < 8; i++) begin
                if (int'(m_tbl[i]) == p && m_qualifies(i)) return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [15:0] exp_iv();
        return (m_mode == 2) ? (16'd1 << m_vec) : 16'd0;
    endfunction

    function automatic logic [7:0] exp_ack();
        return (m_mode == 3) ? (8'd1 << m_vec) : 8'd0;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_mode = 0;
        m_vec  = 0;
        m_cnt  = 0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 3'(i);
    endtask

    // Advance the model with the inputs the DUT is about to see, then clock.
    task automatic cycle();
        logic [7:0] np;
        int nmode;
        int nvec;
        int ncnt;
        int w;
        np    = m_pend | irq_in;
        nmode = m_mode;
        nvec  = m_vec;
        ncnt  = m_cnt;
        w     = m_winner();
        if (m_mode == 0) begin
            if (w >= 0 && inst_boundary) nmode = 1;
        end else if (m_mode == 1) begin
            if (w >= 0) begin
                nmode = 2;
                nvec  = w;
                ncnt  = 0;
            end else begin
                nmode = 0;
            end
        end else if (m_mode == 2) begin
            if (step_done) begin
                if (m_cnt == 8) begin
                    nmode = 3;
                    ncnt  = 0;
                end else begin
                    ncnt = m_cnt + 1;
                end
            end
        end else begin
            np[m_vec] = 1'b0;
            nmode = 0;
        end
        if (pri_wr) m_tbl[pri_addr] = pri_data;
        m_pend = np;
        m_mode = nmode;
        m_vec  = nvec;
        m_cnt  = ncnt;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        irq_in        = '0;
        psw_pri       = '0;
        inst_boundary = 1'b0;
        step_done     = 1'b0;
        pri_wr        = 1'b0;
        pri_addr      = '0;
        pri_data      = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (iv_flags !== 16'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_iv: got %h expected %h", iv_flags, 16'h0);
        end
        n_cmp++;
        if (counter !== 4'd0 || irq_ack !== 8'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_outs: got cnt=%0d ack=%h busy=%b expected 0/00/0", counter, irq_ack, busy);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        psw_pri   = 3'd2;
        irq_in[5] = 1'b1;
        cycle();
        inst_boundary = 1'b1;
        cycle();
        inst_boundary = 1'b0;
        irq_in[5]     = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || iv_flags !== 16'h0) begin
            n_bad++;
            $display("[TB] FAIL latency_arb: got busy=%b iv=%h expected 1/0000", busy, iv_flags);
        end
        cycle();
        n_cmp++;
        if (iv_flags !== 16'h0020 || counter !== 4'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL latency_entry: got iv=%h cnt=%0d busy=%b expected 0020/0/1", iv_flags, counter, busy);
        end
        step_done = 1'b1;
        repeat (9) cycle();
        step_done = 1'b0;
        cycle();
    endtask

    task automatic test_tie_and_steps();
        apply_reset();
        pri_wr = 1'b1; pri_addr = 3'd3; pri_data = 3'd6;
        cycle();
        pri_addr = 3'd6;
        cycle();
        pri_wr  = 1'b0;
        psw_pri = 3'd2;
        irq_in  = 8'h48;
        cycle();
        irq_in        = 8'h00;
        inst_boundary = 1'b1;
        cycle();
        inst_boundary = 1'b0;
        cycle();
        n_cmp++;
        if (iv_flags !== 16'h0008) begin
            n_bad++;
            $display("[TB] FAIL tie_winner: got %h expected %h", iv_flags, 16'h0008);
        end
        step_done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (counter !== 4'(k) || iv_flags !== 16'h0008) begin
                n_bad++;
                $display("[TB] FAIL step_count: got cnt=%0d iv=%h expected %0d/0008", counter, iv_flags, k);
            end
            cycle();
        end
        step_done = 1'b0;
        n_cmp++;
        if (irq_ack !== 8'h08 || iv_flags !== 16'h0 || counter !== 4'd0) begin
            n_bad++;
            $display("[TB] FAIL ack_pulse: got ack=%h iv=%h cnt=%0d expected 08/0000/0", irq_ack, iv_flags, counter);
        end
        cycle();
        n_cmp++;
        if (irq_ack !== 8'h00 || busy !== 1'b0 || iv_flags !== 16'h0) begin
            n_bad++;
            $display("[TB] FAIL ack_end: got ack=%h busy=%b iv=%h expected 00/0/0000", irq_ack, busy, iv_flags);
        end
        inst_boundary = 1'b1;
        cycle();
        inst_boundary = 1'b0;
        cycle();
        n_cmp++;
        if (iv_flags !== 16'h0040) begin
            n_bad++;
            $display("[TB] FAIL tie_second: got %h expected %h", iv_flags, 16'h0040);
        end
        step_done = 1'b1;
        repeat (9) cycle();
        step_done = 1'b0;
        cycle();
    endtask

    task automatic test_mask();
        apply_reset();
        psw_pri       = 3'd7;
        irq_in        = 8'h10;
        inst_boundary = 1'b1;
        repeat (5) cycle();
        n_cmp++;
        if (busy !== 1'b0 || iv_flags !== 16'h0) begin
            n_bad++;
            $display("[TB] FAIL mask_psw: got busy=%b iv=%h expected 0/0000", busy, iv_flags);
        end
        irq_in = 8'h90;
        repeat (4) cycle();
`ifdef INT_CTRL_NMI_EN
        n_cmp++;
        if (iv_flags !== 16'h0080) begin
            n_bad++;
            $display("[TB] FAIL nmi_entry: got %h expected %h", iv_flags, 16'h0080);
        end
`else
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL src7_masked: got busy=%b expected 0", busy);
        end
`endif
        irq_in        = 8'h00;
        inst_boundary = 1'b0;
    endtask

    task automatic test_reset_abort();
        int acks;
        apply_reset();
        irq_in[2]     = 1'b1;
        inst_boundary = 1'b1;
        cycle();
        cycle();
        inst_boundary = 1'b0;
        cycle();
        step_done = 1'b1;
        repeat (4) cycle();
        step_done = 1'b0;
        n_cmp++;
        if (counter !== 4'd4 || iv_flags !== 16'h0004) begin
            n_bad++;
            $display("[TB] FAIL abort_setup: got cnt=%0d iv=%h expected 4/0004", counter, iv_flags);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (iv_flags !== 16'h0 || counter !== 4'd0 || irq_ack !== 8'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort_immediate: got iv=%h cnt=%0d ack=%h busy=%b expected all 0", iv_flags, counter, irq_ack, busy);
        end
        irq_in = 8'h00;
        acks   = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (irq_ack !== 8'h0) acks++;
        end
        rst_n = 1'b1;
        model_reset();
        inst_boundary = 1'b1;
        step_done     = 1'b1;
        repeat (20) begin
            cycle();
            if (irq_ack !== 8'h0 || busy !== 1'b0) acks++;
        end
        inst_boundary = 1'b0;
        step_done     = 1'b0;
        n_cmp++;
        if (acks !== 0) begin
            n_bad++;
            $display("[TB] FAIL abort_no_ack: got %0d active cycles expected 0", acks);
        end
    endtask

    task automatic test_priwr_race();
        apply_reset();
        irq_in[1] = 1'b1;
        cycle();
        irq_in        = 8'h00;
        inst_boundary = 1'b1;
        pri_wr = 1'b1; pri_addr = 3'd1; pri_data = 3'd0;
        cycle();
        pri_wr        = 1'b0;
        inst_boundary = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL race_arb: got busy=%b expected 1", busy);
        end
        cycle();
        n_cmp++;
        if (busy !== 1'b0 || iv_flags !== 16'h0) begin
            n_bad++;
            $display("[TB] FAIL race_idle: got busy=%b iv=%h expected 0/0000", busy, iv_flags);
        end
        inst_boundary = 1'b1;
        repeat (3) cycle();
        inst_boundary = 1'b0;
        n_cmp++;
        if (iv_flags !== 16'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL race_stays: got busy=%b iv=%h expected 0/0000", busy, iv_flags);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            irq_in        = 8'($urandom & $urandom & $urandom);
            psw_pri       = 3'($urandom_range(0, 4));
            inst_boundary = 1'($urandom_range(0, 1));
            step_done     = ($urandom_range(0, 2) != 0);
            pri_wr        = ($urandom_range(0, 15) == 0);
            pri_addr      = 3'($urandom);
            pri_data      = 3'($urandom);
            cycle();
            n_cmp++;
            if (iv_flags !== exp_iv() || irq_ack !== exp_ack() ||
                counter !== 4'(m_cnt) || busy !== (m_mode != 0)) begin
                n_bad++;
                $display("[TB] FAIL random_c%0d: got iv=%h ack=%h cnt=%0d busy=%b expected %h/%h/%0d/%b",
                         c, iv_flags, irq_ack, counter, busy, exp_iv(), exp_ack(), m_cnt, (m_mode != 0));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        #2;
        test_reset();
        test_latency();
        test_tie_and_steps();
        test_mask();
        test_reset_abort();
        test_priwr_race();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
